conv_window_feeder: RTL and testbench

Initiator side of the convolution handshake: accepts a raster-order stream of 4-bit pixels, keeps two line buffers, and forms each 3x3 window. For every complete window it drives the window and `calc_enable` to a convolution unit, then waits for `calc_done`. It captures the 10-bit `conv` result and presents it on a valid/ready result port. It sits between the pixel source and the X/Y convolution blocks.

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_window_feeder_if.sv | 27 ++
 rtl/conv_line_buffer.sv | 36 +++
 rtl/conv_window_feeder.sv | 117 +++++++++++
 tb/tb_conv_window_feeder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window feeder slice.
package conv_pkg;

   localparam int unsigned PIX_W     = 4;
   localparam int unsigned CONV_W    = 10;
   localparam int unsigned DEF_IMG_W = 16;

   typedef logic [PIX_W-1:0]  pixel_t;
   typedef logic [CONV_W-1:0] conv_t;
   typedef pixel_t [2:0][2:0] window_t;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/conv_window_feeder_if.sv
// Pixel stream, convolution request and result port of the window feeder.
interface conv_window_feeder_if;
   import conv_pkg::*;

   logic    frame_start;
   logic    pix_valid;
   pixel_t  pix_data;
   logic    pix_ready;
   window_t pixels;
   logic    calc_enable;
   logic    calc_done;
   conv_t   conv;
   logic    res_valid;
   conv_t   res_data;
   logic    res_ready;

   modport master (
      input  frame_start, pix_valid, pix_data, calc_done, conv, res_ready,
      output pix_ready, pixels, calc_enable, res_valid, res_data
   );

   modport slave (
      output frame_start, pix_valid, pix_data, calc_done, conv, res_ready,
      input  pix_ready, pixels, calc_enable, res_valid, res_data
   );

endinterface

// File: rtl/conv_line_buffer.sv
// Two one-row pixel delay lines indexed by column; reads return the pre-write value.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int unsigned IMG_W = DEF_IMG_W,
   parameter int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             wr_en_i,
   input  logic [COL_W-1:0] addr_i,
   input  pixel_t           wdata_i,
   output pixel_t           rd0_c_o,
   output pixel_t           rd1_c_o
);

   pixel_t lb0_q [IMG_W];
   pixel_t lb1_q [IMG_W];

   assign rd0_c_o = lb0_q[addr_i];
   assign rd1_c_o = lb1_q[addr_i];

   // lb0 holds the row two above the incoming pixel, lb1 the row directly above
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int unsigned i = 0; i < IMG_W; i++) begin
            lb0_q[i] <= '0;
            lb1_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         lb0_q[addr_i] <= lb1_q[addr_i];
         lb1_q[addr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/conv_window_feeder.sv
// Forms 3x3 windows from a raster pixel stream, requests a convolution, returns the result.
// FEEDER_CLAMP_EN: saturate the captured result to 255.
module conv_window_feeder
   import conv_pkg::*;
#(
   parameter int unsigned IMG_W = DEF_IMG_W
) (
   input logic                  clk,
   input logic                  n_rst,
   conv_window_feeder_if.master fdr_if
);

   localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned ROW_W = 2;

   feeder_state_t    state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d, row_eff;
   logic [COL_W-1:0] col_q, col_d, col_eff;
   window_t          win_q, win_d;
   conv_t            res_q, res_d, conv_sel;
   logic             pix_ready_q, calc_enable_q, res_valid_q;
   logic             acc;
   pixel_t           lb0_rd, lb1_rd;

   // frame_start restarts counting with the pixel offered in the same cycle
   assign acc     = fdr_if.pix_valid & (fdr_if.frame_start | (state_q == FILL));
   assign col_eff = fdr_if.frame_start ? '0 : col_q;
   assign row_eff = fdr_if.frame_start ? '0 : row_q;

`ifdef FEEDER_CLAMP_EN
   assign conv_sel = (fdr_if.conv > CONV_W'(255)) ? CONV_W'(255) : fdr_if.conv;
`else
   assign conv_sel = fdr_if.conv;
`endif

   conv_line_buffer #(
      .IMG_W (IMG_W),
      .COL_W (COL_W)
   ) u_line_buffer (
      .clk     (clk),
      .n_rst   (n_rst),
      .wr_en_i (acc),
      .addr_i  (col_eff),
      .wdata_i (fdr_if.pix_data),
      .rd0_c_o (lb0_rd),
      .rd1_c_o (lb1_rd)
   );

   always_comb begin
      state_d = state_q;
      row_d   = row_eff;
      col_d   = col_eff;
      win_d   = win_q;
      res_d   = res_q;

      unique case (state_q)
         FILL: ;
         CALC: if (fdr_if.calc_done && !fdr_if.frame_start) begin
            res_d   = conv_sel;
            state_d = HOLD;
         end
         HOLD: if (fdr_if.res_ready) state_d = FILL;
         default: state_d = FILL;
      endcase

      if (acc) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb0_rd;
         win_d[1][2] = lb1_rd;
         win_d[2][2] = fdr_if.pix_data;

         if (col_eff == COL_W'(IMG_W - 1)) begin
            col_d = '0;
            if (row_eff != ROW_W'(2)) row_d = row_eff + ROW_W'(1);
         end else begin
            col_d = col_eff + COL_W'(1);
         end

         // windows never straddle a row wrap: only cols 2..IMG_W-1 of row>=2 complete one
         if (row_eff == ROW_W'(2) && col_eff >= COL_W'(2)) state_d = CALC;
      end

      if (fdr_if.frame_start) state_d = FILL;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q       <= FILL;
         row_q         <= '0;
         col_q         <= '0;
         win_q         <= '0;
         res_q         <= '0;
         pix_ready_q   <= 1'b1;
         calc_enable_q <= 1'b0;
         res_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         col_q         <= col_d;
         win_q         <= win_d;
         res_q         <= res_d;
         pix_ready_q   <= (state_d == FILL);
         calc_enable_q <= (state_d == CALC);
         res_valid_q   <= (state_d == HOLD);
      end
   end

   assign fdr_if.pix_ready   = pix_ready_q;
   assign fdr_if.pixels      = win_q;
   assign fdr_if.calc_enable = calc_enable_q;
   assign fdr_if.res_valid   = res_valid_q;
   assign fdr_if.res_data    = res_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder with a 4-pixel-wide image.
module tb_conv_window_feeder;
   import conv_pkg::*;

   localparam int unsigned W = 4;
`ifdef FEEDER_CLAMP_EN
   localparam conv_t EXP300 = 10'd255;
`else
   localparam conv_t EXP300 = 10'd300;
`endif

   logic clk = 1'b0;
   logic n_rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   conv_window_feeder_if bus ();

   conv_window_feeder #(.IMG_W(W)) u_dut (
      .clk    (clk),
      .n_rst  (n_rst),
      .fdr_if (bus)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic window_t ramp_win(input int off);
      window_t w;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[r][c] = PIX_W'(r * int'(W) + c + off);
      return w;
   endfunction

   // Offers one pixel from a negedge and returns at the negedge after it is accepted
   task automatic send_pix(input pixel_t d);
      int n = 0;
      bus.pix_valid = 1'b1;
      bus.pix_data  = d;
      while (!bus.pix_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check_eq("pix_accept_timeout", 64'(bus.pix_ready), 64'(1));
      @(posedge clk);
      @(negedge clk);
   endtask

   // Plays the convolution unit: calc_done after lat cycles of calc_enable
   task automatic do_conv(input int lat, input conv_t val);
      logic leak = 1'b0;
      repeat (lat - 1) begin
         @(negedge clk);
         leak |= bus.pix_ready;
      end
      bus.calc_done = 1'b1;
      bus.conv      = val;
      @(negedge clk);
      bus.calc_done = 1'b0;
      check_eq("pix_ready_in_calc", 64'(leak), 64'(0));
      check_eq("calc_enable_fall", 64'(bus.calc_enable), 64'(0));
      check_eq("res_valid_rise", 64'(bus.res_valid), 64'(1));
   endtask

   task automatic take_result(input conv_t exp, input int hold);
      check_eq("res_data", 64'(bus.res_data), 64'(exp));
      repeat (hold) begin
         @(negedge clk);
         check_eq("res_valid_hold", 64'(bus.res_valid), 64'(1));
         check_eq("res_data_hold", 64'(bus.res_data), 64'(exp));
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      check_eq("res_valid_drop", 64'(bus.res_valid), 64'(0));
      check_eq("pix_ready_return", 64'(bus.pix_ready), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_rst           = 1'b1;
      bus.frame_start = 1'b0;
      bus.pix_valid   = 1'b0;
      bus.pix_data    = '0;
      bus.calc_done   = 1'b0;
      bus.conv        = '0;
      bus.res_ready   = 1'b0;
      #1 n_rst = 1'b0;
      #2;
      check_eq("rst_pix_ready", 64'(bus.pix_ready), 64'(1));
      check_eq("rst_calc_enable", 64'(bus.calc_enable), 64'(0));
      check_eq("rst_res_valid", 64'(bus.res_valid), 64'(0));
      check_eq("rst_res_data", 64'(bus.res_data), 64'(0));
      check_eq("rst_pixels", 64'(bus.pixels), 64'(0));
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      // Frame 1: 0..11 with no stalls, pixel 11 offered throughout CALC/HOLD
      for (int i = 0; i < 10; i++) send_pix(PIX_W'(i));
      check_eq("no_window_before_col2", 64'(bus.calc_enable), 64'(0));
      send_pix(4'd10);
      bus.pix_data = 4'd11;
      check_eq("win1_calc_enable", 64'(bus.calc_enable), 64'(1));
      check_eq("win1_pixels", 64'(bus.pixels), 64'(ramp_win(0)));
      check_eq("win1_pix_ready", 64'(bus.pix_ready), 64'(0));
      do_conv(9, 10'd300);
      take_result(EXP300, 5);
      @(posedge clk);
      @(negedge clk);
      bus.pix_valid = 1'b0;
      check_eq("win2_calc_enable", 64'(bus.calc_enable), 64'(1));
      check_eq("win2_pixels", 64'(bus.pixels), 64'(ramp_win(1)));
      do_conv(2, 10'd100);
      take_result(10'd100, 0);
      repeat (4) @(negedge clk);
      check_eq("only_two_windows", 64'(bus.calc_enable), 64'(0));
      check_eq("idle_res_valid", 64'(bus.res_valid), 64'(0));

      // Stray calc_done while filling
      bus.calc_done = 1'b1;
      bus.conv      = 10'd5;
      @(negedge clk);
      bus.calc_done = 1'b0;
      @(negedge clk);
      check_eq("stray_done_res_valid", 64'(bus.res_valid), 64'(0));
      check_eq("stray_done_pix_ready", 64'(bus.pix_ready), 64'(1));
      check_eq("stray_done_res_data", 64'(bus.res_data), 64'(100));

      // frame_start aborts a pending convolution
      send_pix(4'd1);
      send_pix(4'd2);
      send_pix(4'd3);
      bus.pix_valid = 1'b0;
      check_eq("pre_abort_calc_enable", 64'(bus.calc_enable), 64'(1));
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      check_eq("abort_calc_enable", 64'(bus.calc_enable), 64'(0));
      check_eq("abort_pix_ready", 64'(bus.pix_ready), 64'(1));

      // New 3x4 frame of sevens
      for (int i = 0; i < 10; i++) send_pix(4'd7);
      check_eq("sevens_no_early_window", 64'(bus.calc_enable), 64'(0));
      send_pix(4'd7);
      check_eq("sevens_win1", 64'(bus.pixels), 64'(36'h777777777));
      do_conv(3, 10'd50);
      take_result(10'd50, 0);
      send_pix(4'd7);
      bus.pix_valid = 1'b0;
      check_eq("sevens_win2_enable", 64'(bus.calc_enable), 64'(1));
      check_eq("sevens_win2", 64'(bus.pixels), 64'(36'h777777777));
      do_conv(3, 10'd60);
      take_result(10'd60, 0);

      // Reset while holding a result
      send_pix(4'd1);
      send_pix(4'd2);
      send_pix(4'd3);
      bus.pix_valid = 1'b0;
      do_conv(2, 10'd300);
      n_rst = 1'b0;
      #1;
      check_eq("hold_rst_res_valid", 64'(bus.res_valid), 64'(0));
      check_eq("hold_rst_res_data", 64'(bus.res_data), 64'(0));
      check_eq("hold_rst_calc_enable", 64'(bus.calc_enable), 64'(0));
      check_eq("hold_rst_pix_ready", 64'(bus.pix_ready), 64'(1));
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) send_pix(PIX_W'(i));
      check_eq("refill_no_early_window", 64'(bus.calc_enable), 64'(0));
      send_pix(4'd10);
      bus.pix_valid = 1'b0;
      check_eq("refill_calc_enable", 64'(bus.calc_enable), 64'(1));
      check_eq("refill_pixels", 64'(bus.pixels), 64'(ramp_win(0)));
      do_conv(2, 10'd12);
      take_result(10'd12, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
